// File: rtl/reg_file_rn.sv
// ---------------------------------------------------------------------------
// reg_file_rn
//   Architectural register file plus register alias table (RAT) for the
//   out-of-order core. Each architectural register holds its committed value
//   and the ROB tag of its newest in-flight producer (tag 0 = no producer).
//   Every read port resolves its source register combinationally into either
//   a ready value (Q=0) or a pending tag (Q!=0). Pending operands are bypassed
//   from the ROB, the commit port and the CDB channels.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   rdy             global enable; low freezes all state (reads still work)
//   rs              NRD packed source register indices
//   V, Q            NRD packed resolved values / pending tags (Q=0 -> V valid)
//   rob_qid         NRD packed RAT tags presented to the ROB
//   rob_qready/val  ROB readiness and result for each rob_qid
//   cmt_*           commit port (destination, ROB tag, value)
//   ren_*           rename port (destination, new ROB tag)
//   cdb_*           NCDB packed CDB broadcast channels
//   flush           misprediction flush, clears every RAT tag
// ---------------------------------------------------------------------------
module reg_file_rn #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int REGBW = 5,
  parameter int ROBBW = 4,
  parameter int NRD   = 2,
  parameter int NCDB  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRD*REGBW-1:0]  rs,
  output logic [NRD*XLEN-1:0]   V,
  output logic [NRD*ROBBW-1:0]  Q,
  output logic [NRD*ROBBW-1:0]  rob_qid,
  input  logic [NRD-1:0]        rob_qready,
  input  logic [NRD*XLEN-1:0]   rob_qval,
  input  logic                  cmt_en,
  input  logic [REGBW-1:0]      cmt_rd,
  input  logic [ROBBW-1:0]      cmt_id,
  input  logic [XLEN-1:0]       cmt_val,
  input  logic                  ren_en,
  input  logic [REGBW-1:0]      ren_rd,
  input  logic [ROBBW-1:0]      ren_id,
  input  logic [NCDB-1:0]       cdb_en,
  input  logic [NCDB*ROBBW-1:0] cdb_id,
  input  logic [NCDB*XLEN-1:0]  cdb_val,
  input  logic                  flush
);

  logic [XLEN-1:0]  r_val [NREG];
  logic [ROBBW-1:0] r_tag [NREG];

  // Commit, rename and flush are written in that order so that later
  // non-blocking assignments win: a rename beats a same-register commit
  // tag-clear, and a flush beats everything on the tags. Entry 0 is never
  // written, which keeps x0 hardwired to zero with no producer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      if (cmt_en && (cmt_rd != '0)) begin
        r_val[cmt_rd] <= cmt_val;
        // A stale commit (register renamed again since) keeps the newer tag.
        if (r_tag[cmt_rd] == cmt_id) begin
          r_tag[cmt_rd] <= '0;
        end
      end
      if (ren_en && (ren_rd != '0) && !flush) begin
        r_tag[ren_rd] <= ren_id;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) begin
          r_tag[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [REGBW-1:0] w_rs;
    logic [ROBBW-1:0] w_tag;
    logic [XLEN-1:0]  w_val;
    logic             w_cdbHit;
    logic [XLEN-1:0]  w_cdbVal;
    logic [XLEN-1:0]  w_v;
    logic [ROBBW-1:0] w_q;

    assign w_rs  = rs[g*REGBW +: REGBW];
    assign w_tag = r_tag[w_rs];
    assign w_val = r_val[w_rs];

    // Scan channels from highest to lowest so the lowest matching index wins.
    always_comb begin
      w_cdbHit = 1'b0;
      w_cdbVal = '0;
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (cdb_en[k] && (cdb_id[k*ROBBW +: ROBBW] == w_tag)) begin
          w_cdbHit = 1'b1;
          w_cdbVal = cdb_val[k*XLEN +: XLEN];
        end
      end
    end

    always_comb begin
      w_v = '0;
      w_q = '0;
      if (w_rs != '0) begin
        if (w_tag == '0) begin
          w_v = w_val;
        end else if (rob_qready[g]) begin
          w_v = rob_qval[g*XLEN +: XLEN];
        end else if (cmt_en && (cmt_id == w_tag)) begin
          w_v = cmt_val;
        end else if (w_cdbHit) begin
          w_v = w_cdbVal;
        end else begin
          w_q = w_tag;
        end
      end
    end

    assign V[g*XLEN +: XLEN]        = w_v;
    assign Q[g*ROBBW +: ROBBW]      = w_q;
    assign rob_qid[g*ROBBW +: ROBBW] = (w_rs == '0) ? '0 : w_tag;
  end

endmodule

// File: tb/tb_reg_file_rn.sv
// ---------------------------------------------------------------------------
// tb_reg_file_rn
//   Self-checking bench for reg_file_rn. A behavioural register/alias model
//   (plain arrays) is updated on every accepted clock edge. A compare process
//   checks all read ports against it on every falling edge. Directed steps
//   add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_file_rn;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REGBW = 5;
  localparam int ROBBW = 4;
  localparam int NRD   = 2;
  localparam int NCDB  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rdy;
  logic [NRD*REGBW-1:0]  rs;
  logic [NRD*XLEN-1:0]   V;
  logic [NRD*ROBBW-1:0]  Q;
  logic [NRD*ROBBW-1:0]  rob_qid;
  logic [NRD-1:0]        rob_qready;
  logic [NRD*XLEN-1:0]   rob_qval;
  logic                  cmt_en;
  logic [REGBW-1:0]      cmt_rd;
  logic [ROBBW-1:0]      cmt_id;
  logic [XLEN-1:0]       cmt_val;
  logic                  ren_en;
  logic [REGBW-1:0]      ren_rd;
  logic [ROBBW-1:0]      ren_id;
  logic [NCDB-1:0]       cdb_en;
  logic [NCDB*ROBBW-1:0] cdb_id;
  logic [NCDB*XLEN-1:0]  cdb_val;
  logic                  flush;

  int nChecks = 0;
  int nFails  = 0;

  logic [XLEN-1:0]  mVal [NREG];
  logic [ROBBW-1:0] mTag [NREG];

  reg_file_rn #(
    .XLEN(XLEN), .NREG(NREG), .REGBW(REGBW), .ROBBW(ROBBW), .NRD(NRD), .NCDB(NCDB)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs(rs), .V(V), .Q(Q), .rob_qid(rob_qid),
    .rob_qready(rob_qready), .rob_qval(rob_qval),
    .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_id(cmt_id), .cmt_val(cmt_val),
    .ren_en(ren_en), .ren_rd(ren_rd), .ren_id(ren_id),
    .cdb_en(cdb_en), .cdb_id(cdb_id), .cdb_val(cdb_val), .flush(flush)
  );

  always #5 clk = ~clk;

  // Model state: the reset clear happens the instant rst falls.
  initial begin
    for (int i = 0; i < NREG; i++) begin
      mVal[i] = '0;
      mTag[i] = '0;
    end
  end

  always @(negedge rst) begin
    for (int i = 0; i < NREG; i++) begin
      mVal[i] = '0;
      mTag[i] = '0;
    end
  end

  // The model applies commit, then rename, then flush at each accepted edge.
  always @(posedge clk) begin
    if (rst === 1'b1 && rdy === 1'b1) begin
      if (cmt_en && cmt_rd != 0) begin
        mVal[cmt_rd] = cmt_val;
        if (mTag[cmt_rd] == cmt_id) mTag[cmt_rd] = '0;
      end
      if (ren_en && ren_rd != 0 && !flush) mTag[ren_rd] = ren_id;
      if (flush) for (int i = 0; i < NREG; i++) mTag[i] = '0;
    end
  end

  function automatic void modelRead(input int j, output logic [XLEN-1:0] ev,
                                    output logic [ROBBW-1:0] eq, output logic [ROBBW-1:0] eid);
    logic [REGBW-1:0] r;
    logic [ROBBW-1:0] t;
    bit found;
    r = rs[j*REGBW +: REGBW];
    t = mTag[r];
    ev = '0;
    eq = '0;
    eid = (r == 0) ? '0 : t;
    if (r == 0) begin
      ev = '0;
    end else if (t == 0) begin
      ev = mVal[r];
    end else if (rob_qready[j]) begin
      ev = rob_qval[j*XLEN +: XLEN];
    end else if (cmt_en && cmt_id == t) begin
      ev = cmt_val;
    end else begin
      found = 1'b0;
      for (int k = 0; k < NCDB; k++) begin
        if (!found && cdb_en[k] && cdb_id[k*ROBBW +: ROBBW] == t) begin
          ev = cdb_val[k*XLEN +: XLEN];
          found = 1'b1;
        end
      end
      if (!found) eq = t;
    end
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: all ports against the model.
  always @(negedge clk) begin
    logic [XLEN-1:0]  ev;
    logic [ROBBW-1:0] eq, eid;
    for (int j = 0; j < NRD; j++) begin
      modelRead(j, ev, eq, eid);
      check($sformatf("model V[%0d]", j), V[j*XLEN +: XLEN], ev);
      check($sformatf("model Q[%0d]", j), XLEN'(Q[j*ROBBW +: ROBBW]), XLEN'(eq));
      check($sformatf("model qid[%0d]", j), XLEN'(rob_qid[j*ROBBW +: ROBBW]), XLEN'(eid));
    end
  end

  // Advance one cycle and put the control inputs back to idle.
  task automatic applyStimulus(input logic [REGBW-1:0] rs0, input logic [REGBW-1:0] rs1);
    @(posedge clk);
    #1;
    rs = {rs1, rs0};
    rdy = 1'b1;
    rob_qready = '0;
    rob_qval = '0;
    cmt_en = 1'b0;
    cmt_rd = '0;
    cmt_id = '0;
    cmt_val = '0;
    ren_en = 1'b0;
    ren_rd = '0;
    ren_id = '0;
    cdb_en = '0;
    cdb_id = '0;
    cdb_val = '0;
    flush = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int port,
                             input logic [XLEN-1:0] expV, input logic [ROBBW-1:0] expQ);
    check({name, " V"}, V[port*XLEN +: XLEN], expV);
    check({name, " Q"}, XLEN'(Q[port*ROBBW +: ROBBW]), XLEN'(expQ));
  endtask

  task automatic checkQid(input string name, input int port, input logic [ROBBW-1:0] expId);
    check({name, " qid"}, XLEN'(rob_qid[port*ROBBW +: ROBBW]), XLEN'(expId));
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    rs = '0;
    rob_qready = '0;
    rob_qval = '0;
    cmt_en = 1'b0;
    cmt_rd = '0;
    cmt_id = '0;
    cmt_val = '0;
    ren_en = 1'b0;
    ren_rd = '0;
    ren_id = '0;
    cdb_en = '0;
    cdb_id = '0;
    cdb_val = '0;
    flush = 1'b0;

    applyStimulus(5, 0);
    applyStimulus(5, 0);
    rst = 1'b1;
    #1;
    checkOutput("reset x5", 0, 32'h0, 4'd0);

    // Rename x5 -> 3, not visible in the same cycle
    applyStimulus(5, 5);
    ren_en = 1'b1; ren_rd = 5; ren_id = 4'd3;
    #1;
    checkOutput("rename same cycle", 0, 32'h0, 4'd0);
    applyStimulus(5, 5);
    #1;
    checkOutput("renamed x5 p0", 0, 32'h0, 4'd3);
    checkOutput("renamed x5 p1", 1, 32'h0, 4'd3);
    checkQid("renamed x5", 0, 4'd3);
    cdb_en = 2'b10; cdb_id = {4'd3, 4'd0}; cdb_val = {32'hDEAD, 32'h0};
    #1;
    checkOutput("cdb ch1 bypass", 0, 32'hDEAD, 4'd0);
    checkQid("cdb ch1 bypass", 0, 4'd3);

    // Both channels hit: lowest index wins
    applyStimulus(5, 5);
    cdb_en = 2'b11; cdb_id = {4'd3, 4'd3}; cdb_val = {32'h22, 32'h11};
    #1;
    checkOutput("cdb priority", 0, 32'h11, 4'd0);

    // ROB ready on port 0 only
    applyStimulus(5, 5);
    rob_qready = 2'b01; rob_qval = {32'h0, 32'hAAAA};
    #1;
    checkOutput("rob bypass p0", 0, 32'hAAAA, 4'd0);
    checkOutput("rob not ready p1", 1, 32'h0, 4'd3);

    // Commit x5 tag 3
    applyStimulus(5, 5);
    cmt_en = 1'b1; cmt_rd = 5; cmt_id = 4'd3; cmt_val = 32'h1234;
    #1;
    checkOutput("commit bypass", 0, 32'h1234, 4'd0);
    applyStimulus(5, 5);
    #1;
    checkOutput("after commit", 0, 32'h1234, 4'd0);
    checkQid("after commit", 0, 4'd0);

    // Stale commit keeps newer tag
    applyStimulus(5, 5);
    ren_en = 1'b1; ren_rd = 5; ren_id = 4'd7;
    applyStimulus(5, 5);
    cmt_en = 1'b1; cmt_rd = 5; cmt_id = 4'd3; cmt_val = 32'd9;
    #1;
    checkOutput("stale commit no bypass", 0, 32'h0, 4'd7);
    applyStimulus(5, 5);
    #1;
    checkOutput("stale commit tag kept", 0, 32'h0, 4'd7);
    checkQid("stale commit tag kept", 0, 4'd7);

    // Commit and rename on the same register
    applyStimulus(6, 6);
    ren_en = 1'b1; ren_rd = 6; ren_id = 4'd4;
    applyStimulus(6, 6);
    cmt_en = 1'b1; cmt_rd = 6; cmt_id = 4'd4; cmt_val = 32'h66;
    ren_en = 1'b1; ren_rd = 6; ren_id = 4'd6;
    #1;
    checkOutput("collision bypass", 0, 32'h66, 4'd0);
    applyStimulus(6, 6);
    #1;
    checkOutput("rename beats clear", 0, 32'h0, 4'd6);

    // Flush with same-cycle rename and commit
    applyStimulus(7, 8);
    flush = 1'b1;
    ren_en = 1'b1; ren_rd = 7; ren_id = 4'd5;
    cmt_en = 1'b1; cmt_rd = 8; cmt_id = 4'd1; cmt_val = 32'h88;
    #1;
    checkOutput("flush cycle x7", 0, 32'h0, 4'd0);
    applyStimulus(5, 6);
    #1;
    checkOutput("flushed x5", 0, 32'd9, 4'd0);
    checkOutput("flushed x6", 1, 32'h66, 4'd0);
    applyStimulus(7, 8);
    #1;
    checkOutput("flush drops rename", 0, 32'h0, 4'd0);
    checkQid("flush drops rename", 0, 4'd0);
    checkOutput("flush keeps commit", 1, 32'h88, 4'd0);

    // x0 is never written
    applyStimulus(0, 0);
    ren_en = 1'b1; ren_rd = 0; ren_id = 4'd2;
    cmt_en = 1'b1; cmt_rd = 0; cmt_id = 4'd2; cmt_val = 32'h55;
    applyStimulus(0, 0);
    #1;
    checkOutput("x0 hardwired", 0, 32'h0, 4'd0);
    checkQid("x0 hardwired", 0, 4'd0);

    // rdy=0 freezes state but reads still work
    applyStimulus(9, 8);
    rdy = 1'b0;
    ren_en = 1'b1; ren_rd = 9; ren_id = 4'd2;
    cmt_en = 1'b1; cmt_rd = 9; cmt_id = 4'd0; cmt_val = 32'h99;
    #1;
    checkOutput("rdy low read", 1, 32'h88, 4'd0);
    applyStimulus(9, 9);
    #1;
    checkOutput("rdy low frozen", 0, 32'h0, 4'd0);
    checkQid("rdy low frozen", 0, 4'd0);

    // Asynchronous reset mid-operation
    applyStimulus(5, 8);
    ren_en = 1'b1; ren_rd = 5; ren_id = 4'd3;
    applyStimulus(5, 8);
    #1;
    checkOutput("pre-reset x5", 0, 32'h0, 4'd3);
    rst = 1'b0;
    #1;
    checkOutput("async reset x5", 0, 32'h0, 4'd0);
    checkOutput("async reset x8", 1, 32'h0, 4'd0);
    applyStimulus(5, 8);
    applyStimulus(5, 8);
    rst = 1'b1;
    #1;
    checkOutput("reset release", 0, 32'h0, 4'd0);
    applyStimulus(5, 8);
    #1;
    checkOutput("after release", 0, 32'h0, 4'd0);
    checkOutput("after release x8", 1, 32'h0, 4'd0);

    applyStimulus(0, 0);
    applyStimulus(0, 0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/reg_file_rn.md
Name: reg_file_rn

Overview:
Parametrised architectural register file and register alias table (RAT) for the out-of-order core. It holds committed register values and, for each register, the ROB tag of its newest in-flight producer. It resolves NRD source operands per cycle into a value (V) or a pending tag (Q), with bypass from the ROB, the commit port and NCDB broadcast buses. New relative to the previous generation: N read ports, N CDB channels, x0 hardwiring, commit-port bypass, full-RAT flush on misprediction, and defined reset of all state.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count (power of two)
REGBW, 5, log2(NREG)
ROBBW, 4, ROB tag width; tag 0 = "no producer", valid tags 1..2^ROBBW-1
NRD, 2, source-operand read ports
NCDB, 2, CDB broadcast channels

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
rdy  in  1  global enable; 0 freezes all state
rs  in  NRD*REGBW  source register per port (port j in slice j)
V  out  NRD*XLEN  resolved operand value per port
Q  out  NRD*ROBBW  pending tag per port; 0 = value valid
rob_qid  out  NRD*ROBBW  RAT tag per port, driven to the ROB
rob_qready  in  NRD  ROB entry for rob_qid[j] has its result
rob_qval  in  NRD*XLEN  ROB result for rob_qid[j]
cmt_en  in  1  commit valid
cmt_rd  in  REGBW  commit destination
cmt_id  in  ROBBW  committing ROB tag
cmt_val  in  XLEN  committed value
ren_en  in  1  rename valid
ren_rd  in  REGBW  renamed destination
ren_id  in  ROBBW  new ROB tag
cdb_en  in  NCDB  CDB channel valid
cdb_id  in  NCDB*ROBBW  CDB tags
cdb_val  in  NCDB*XLEN  CDB values
flush  in  1  misprediction flush

Behaviour:
- State: val[NREG] (XLEN), tag[NREG] (ROBBW). rst low clears both asynchronously. Reads then return V=0, Q=0.
- Reads are combinational, with zero latency. They see the state before this cycle's edge, so a same-cycle rename is not visible.
- rob_qid[j] = tag[rs[j]], or 0 if rs[j]==0.
- Per port j, apply the first matching rule:
  1. rs==0 -> V=0, Q=0.
  2. tag==0 -> V=val[rs], Q=0.
  3. rob_qready[j] -> V=rob_qval[j], Q=0.
  4. cmt_en && cmt_id==tag -> V=cmt_val, Q=0.
  5. Lowest-index channel k with cdb_en[k] && cdb_id[k]==tag -> V=cdb_val[k], Q=0.
  6. Otherwise V=0, Q=tag.
- At the clock edge, when rdy=1 and rst is high, in this order:
  - Commit: if cmt_en && cmt_rd!=0, then val[cmt_rd]<=cmt_val. Additionally, if tag[cmt_rd]==cmt_id, tag[cmt_rd]<=0.
  - Rename: if ren_en && ren_rd!=0 && !flush, then tag[ren_rd]<=ren_id. It overrides a same-cycle commit tag-clear on the same register.
  - Flush: all tag<=0. The same-cycle commit value write still lands. A same-cycle rename is dropped.
- rdy=0: no state changes. Reads still operate.
- Register x0: val[0] and tag[0] are never written; they stay 0.
- A commit whose tag no longer matches (register was renamed again) updates the value only. The newer tag is kept.
- Tags wrap in the ROB. Tag 0 is never issued by the ROB; ren_id==0 is illegal and leaves the behaviour undefined.

Test Plan:
- Reset: rst low mid-operation with tag[5]=3 -> immediately V=0, Q=0 for rs=5. After release, rs=5 reads V=0, Q=0.
- Rename then read: ren x5->tag 3; next cycle rs0=5, not ready, no CDB -> Q=3, rob_qid=3. Same-cycle CDB ch1 {3, 0xDEAD} -> V=0xDEAD, Q=0.
- CDB priority: both channels broadcast tag 3 with 0x11 and 0x22 -> V=0x11.
- Commit: commit x5 tag 3 val 0x1234 with tag[5]=3. Same-cycle read -> V=0x1234 (bypass). Next cycle -> tag[5]=0, V=0x1234.
- Stale commit and collision: tag[5]=7, commit x5 tag 3 val 9 -> val=9, tag stays 7. Commit x6 tag 4 plus rename x6->tag 6 in the same cycle -> tag[6]=6.
- Flush, x0 and rdy: flush with x5, x6 renamed and rename x7 same cycle -> all Q=0, x7 not renamed. Rename/commit to x0 -> reads stay V=0. rdy=0 with rename -> no change.
